// File: rtl/qif_pkg.sv
// Shared QIF definitions: default widths and the saturating clip used by the synapse and neuron.
// Pure combinational helpers; no state, no latency, no backpressure.
package qif_pkg;

   localparam int QIF_W           = 8;
   localparam int QIF_N_IN        = 4;
   localparam int QIF_DECAY_SHIFT = 3;

   typedef struct packed {
      logic        clip;
      logic [31:0] val;
   } qif_clip_t;

   // Clamp a signed full-width value to [0, 2^w-1] and flag whether clamping happened.
   function automatic qif_clip_t qif_clip(input int v, input int w);
      int        hi;
      qif_clip_t r;
      hi     = (1 << w) - 1;
      r.clip = 1'b0;
      r.val  = 32'(v);
      if (v < 0) begin
         r.clip = 1'b1;
         r.val  = '0;
      end else if (v > hi) begin
         r.clip = 1'b1;
         r.val  = 32'(hi);
      end
      return r;
   endfunction

endpackage

// File: rtl/qif_syn_wreg.sv
// Per-channel synaptic weight file: synchronous write, all entries readable combinationally.
// Write visible one edge later; always accepts, no backpressure.
// Addresses at or beyond N_IN match no entry and are dropped.
module qif_syn_wreg #(
   parameter int W    = 8,
   parameter int N_IN = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [$clog2(N_IN)-1:0]   wr_addr,
   input  logic [W-1:0]              wr_data,
   output logic [N_IN*W-1:0]         w_all
);

   localparam int AW = $clog2(N_IN);

   logic [N_IN*W-1:0] w_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         w_q <= '0;
      end else begin
         for (int k = 0; k < N_IN; k++) begin
            if (wr_en && (wr_addr == AW'(k))) begin
               w_q[k*W +: W] <= wr_data;
            end
         end
      end
   end

   assign w_all = w_q;

endmodule

// File: rtl/qif_synapse.sv
// Synaptic current accumulator: weighted spike sum plus exponential decay, clipped to W bits.
// One-cycle latency from spike/tick to i_syn; always ready, no backpressure.
// QIF_SYN_INHIB_EN: weights become signed so spikes can be inhibitory.
module qif_synapse
   import qif_pkg::*;
#(
   parameter int W           = QIF_W,
   parameter int N_IN        = QIF_N_IN,
   parameter int DECAY_SHIFT = QIF_DECAY_SHIFT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_IN-1:0]           spike_in,
   input  logic                      tick,
   input  logic                      w_wr_en,
   input  logic [$clog2(N_IN)-1:0]   w_wr_addr,
   input  logic [W-1:0]              w_wr_data,
   output logic [W-1:0]              i_syn,
   output logic                      sat
);

   localparam int SW = W + $clog2(N_IN) + 1;

   logic [N_IN*W-1:0]    w_all;
   logic signed [SW-1:0] s;
   logic [W-1:0]         dec_sh;
   logic [W-1:0]         d;
   int                   nxt;
   qif_clip_t            clip;

   qif_syn_wreg #(
      .W    (W),
      .N_IN (N_IN)
   ) u_wreg (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (w_wr_en),
      .wr_addr (w_wr_addr),
      .wr_data (w_wr_data),
      .w_all   (w_all)
   );

   // Spike sum uses the weights registered before this edge.
   always_comb begin
      s = '0;
      for (int k = 0; k < N_IN; k++) begin
         if (spike_in[k]) begin
`ifdef QIF_SYN_INHIB_EN
            s = s + SW'($signed(w_all[k*W +: W]));
`else
            s = s + $signed(SW'(w_all[k*W +: W]));
`endif
         end
      end
   end

   // Minimum decrement of 1 lets small currents decay all the way to zero.
   always_comb begin
      dec_sh = i_syn >> DECAY_SHIFT;
      d      = '0;
      if (tick && (i_syn != '0)) begin
         d = (dec_sh == '0) ? W'(1) : dec_sh;
      end
      nxt  = int'(i_syn) - int'(d) + int'(s);
      clip = qif_clip(nxt, W);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         i_syn <= '0;
         sat   <= 1'b0;
      end else begin
         i_syn <= clip.val[W-1:0];
         // val is already clamped to W bits, so its upper bits are always zero.
         sat   <= clip.clip | (|clip.val[31:W]);
      end
   end

endmodule

// File: doc/qif_synapse.md
# qif_synapse

Synaptic current generator feeding the `I_syn` input of the 8-bit quadratic integrate-and-fire neuron. It accepts one-cycle presynaptic spike pulses on `N_IN` channels and adds a programmable per-channel weight to a saturating current accumulator. On every `tick` the accumulator decays exponentially. The registered accumulator value drives `i_syn`, which connects straight to the neuron's current input.

## Interface
Parameters:
- `W`, 8: width of `i_syn` and of each weight
- `N_IN`, 4: number of presynaptic channels, 2..8
- `DECAY_SHIFT`, 3: decay rate; per-tick decrement is `i_syn >> DECAY_SHIFT`

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `spike_in`  in  N_IN  presynaptic spikes; bit k high for one cycle = one event on channel k
- `tick`  in  1  decay strobe (model time step), one cycle
- `w_wr_en`  in  1  weight write enable
- `w_wr_addr`  in  clog2(N_IN)  channel index to write
- `w_wr_data`  in  W  new weight
- `i_syn`  out  W  synaptic current to neuron, unsigned, registered
- `sat`  out  1  one-cycle pulse when the update in the same cycle was clipped

## Operation
- Weight file: `N_IN` x `W` registers, all reset to 0. Write takes effect at the next edge. An address ≥ `N_IN` is ignored.
- Per-cycle update, computed from current-cycle values:
  - Decay term `d`:
    - 0 if `tick`=0 or `i_syn`=0.
    - Otherwise `max(i_syn >> DECAY_SHIFT, 1)`. The minimum of 1 guarantees the current reaches 0.
  - Input term `s`: sum of the weights of all channels with `spike_in[k]`=1.
    - Width is W+clog2(N_IN)+1, so no intermediate overflow.
    - Weights used are the values registered before this edge: a write and a spike on the same channel in the same cycle use the old weight.
  - `next = i_syn - d + s`, computed at full width, then clipped to [0, 2^W-1].
    - `sat` is asserted for the cycle following any clip.
- Spike, tick and write may all occur in the same cycle. Decay is applied to the old value, then spikes are added.
- No state machine beyond the accumulator and weight file. The block is always ready; there is no backpressure.

## Timing
- Reset: `i_syn`=0, `sat`=0, all weights 0. A reset asserted mid-operation discards any in-cycle spike, tick or write.
- Latency: a spike at edge t is visible on `i_syn` after edge t+1 (one register). A tick follows the same timing.
- Weight write to use: a write at edge t can be used by a spike sampled at edge t+1.
- `sat` is high for exactly one cycle per clipped update. Consecutive clipped cycles keep it high.

## Configuration
- `QIF_SYN_INHIB_EN` defined:
  - Weights are two's-complement signed W-bit values, so negative weights are inhibitory.
  - `s` is a signed sum and `next` can fall below 0. It is clipped to 0 and `sat` pulses.
- Not defined:
  - Weights are unsigned. `w_wr_data` 0xCE means +206.
  - The lower clip occurs only via decay, which can never underflow, so the lower clip is never hit.

## Structure
- Shared package `qif_pkg`:
  - Defaults `QIF_W`=8, `QIF_N_IN`=4, `QIF_DECAY_SHIFT`=3.
  - Saturating clip function `qif_clip` (full width -> W bits plus clip flag), shared with the neuron.
- Sub-module `qif_syn_wreg`: weight register file with synchronous write, combinational read of all entries, and synchronous reset.
- Top `qif_synapse` contains the sum tree, decay, clip, and output registers.

## Test plan
Bench parameters: W=8, N_IN=4, DECAY_SHIFT=3.
- Write w0=20. Pulse `spike_in`=0001 -> `i_syn`=20 one cycle later, `sat`=0.
- With `i_syn`=80, pulse `tick` -> 70. From 5, tick -> 4. From 1, tick -> 0. From 0, tick -> stays 0, `sat`=0.
- Write w1=200, w2=100. `spike_in`=0110 -> `i_syn`=255, `sat` high for 1 cycle. A further spike on channel 1 -> 255, `sat` high again.
- With `i_syn`=80 and w0=20, apply `tick` and `spike_in`=0001 in the same cycle -> 90.
- Same cycle: write w3=50 and `spike_in`=1000 with old w3=10 -> +10. Next spike on channel 3 -> +50. Assert `rst` mid-stream -> `i_syn`=0, weights 0, so a following spike adds 0.
- `QIF_SYN_INHIB_EN` defined: w0=0xCE (-50) at `i_syn`=30 -> `i_syn`=0, `sat` pulse. Not defined: same write/spike -> `i_syn`=236.
